mips_cpu_muldiv: RTL and testbench

MIPS_CPU_MULDIV -- requirements
Module: mips_cpu_muldiv

---
 rtl/mips_cpu_muldiv.sv | 131 +++++++++++++
 tb/tb_mips_cpu_muldiv.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_muldiv.sv
// mips_cpu_muldiv: iterative MIPS HI/LO multiply/divide unit.
//   clk, reset        : clock, asynchronous active-high reset
//   clk_enable        : when low every register holds its value
//   start, op, a, b   : request; op 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   busy              : high in RUN and FIX
//   done              : one enabled-cycle pulse, hi/lo valid
//   hi, lo            : product high/low word, or remainder/quotient
// One shift-add / restoring-divide step per enabled cycle on operand
// magnitudes, then a single sign-fix cycle: 34 enabled cycles start-to-done.
module mips_cpu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic             is_div;
  logic             neg_lo;   // product sign (mult) or quotient sign (div)
  logic             neg_hi;   // remainder sign (div only)
  logic             b_zero;
  logic [WIDTH-1:0] a_raw;
  logic [WIDTH-1:0] m;        // multiplicand magnitude or divisor magnitude
  logic [WIDTH-1:0] acc_hi;   // partial product high / partial remainder
  logic [WIDTH-1:0] acc_lo;   // multiplier being shifted out / dividend -> quotient

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift, div_trial;
  logic [2*WIDTH-1:0] prod, prod_fix;

  always_comb begin
    mag_a     = (!op[0] && a[WIDTH-1]) ? -a : a;
    mag_b     = (!op[0] && b[WIDTH-1]) ? -b : b;
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_trial = div_shift - {1'b0, m};
    prod      = {acc_hi, acc_lo};
    prod_fix  = neg_lo ? -prod : prod;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      b_zero <= 1'b0;
      a_raw  <= '0;
      m      <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
    end else if (clk_enable) begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state  <= RUN;
            busy   <= 1'b1;
            count  <= '0;
            is_div <= op[1];
            neg_lo <= !op[0] && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_hi <= !op[0] && a[WIDTH-1];
            b_zero <= (b == '0);
            a_raw  <= a;
            m      <= op[1] ? mag_b : mag_a;
            acc_lo <= op[1] ? mag_a : mag_b;
            acc_hi <= '0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          if (is_div) begin
            // Trial never exceeds WIDTH bits once it succeeds, since remainder < divisor.
            if (!div_trial[WIDTH]) begin
              acc_hi <= div_trial[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi <= div_shift[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
          count <= count + CW'(1);
          if (count == CW'(WIDTH - 1))
            state <= FIX;
        end
        FIX: begin
          if (!is_div) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else if (b_zero) begin
            hi <= a_raw;
            lo <= '1;
          end else begin
            hi <= neg_hi ? -acc_hi : acc_hi;
            lo <= neg_lo ? -acc_lo : acc_lo;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
module tb_mips_cpu_muldiv;

  logic        clk = 1'b0;
  logic        reset, clk_enable, start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  mips_cpu_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start),
    .op(op), .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic from the MIPS definitions.
  function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] mh, output logic [31:0] ml);
    longint      sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    mh = '0;
    ml = '0;
    case (o)
      2'b00: begin p = sx * sy; mh = p[63:32]; ml = p[31:0]; end
      2'b01: begin p = {32'b0, x} * {32'b0, y}; mh = p[63:32]; ml = p[31:0]; end
      2'b10: begin
        if (y == 0) begin mh = x; ml = '1; end
        else begin q = sx / sy; r = sx % sy; ml = q[31:0]; mh = r[31:0]; end
      end
      default: begin
        if (y == 0) begin mh = x; ml = '1; end
        else begin ml = x / y; mh = x % y; end
      end
    endcase
  endfunction

  // Called at a negedge; the following posedge is the capturing edge.
  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
  endtask

  // Counts cycles after the capturing edge until done; returns at that negedge.
  task automatic wait_done(input int stall_at, input int stall_len, input int ign_at,
                           output int lat, output bit run_ok);
    lat = -1;
    run_ok = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c;
        if (busy) run_ok = 1'b0;
        break;
      end
      if (!busy) run_ok = 1'b0;
      if (c == stall_at) clk_enable = 1'b0;
      if (c == stall_at + stall_len) clk_enable = 1'b1;
      if (c == ign_at) begin start = 1'b1; op = 2'b10; a = 32'd1; b = 32'd1; end
      if (c == ign_at + 1) start = 1'b0;
    end
    clk_enable = 1'b1;
    start = 1'b0;
  endtask

  task automatic run_check(input string name, input logic [1:0] o, input logic [31:0] x,
                           input logic [31:0] y, input int stall_at, input int stall_len,
                           input int ign_at, input int exp_lat);
    logic [31:0] mh, ml;
    int lat;
    bit ok;
    model(o, x, y, mh, ml);
    start_op(o, x, y);
    wait_done(stall_at, stall_len, ign_at, lat, ok);
    chk({name, " latency"}, 64'(lat), 64'(exp_lat));
    chk({name, " busy"}, 64'(ok), 64'(1));
    chk({name, " hilo"}, {hi, lo}, {mh, ml});
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2] = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{2'b11, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF};
    vecs[4] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5] = '{2'b10, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[6] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[7] = '{2'b11, 32'd17,       32'd5,        32'd2,        32'd3};
    vecs[8] = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[9] = '{2'b01, 32'd0,        32'hDEADBEEF, 32'd0,        32'd0};

    reset = 1'b1; clk_enable = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    #2;
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset done", 64'(done), 64'(0));
    chk("reset hilo", {hi, lo}, 64'(0));
    @(negedge clk);
    reset = 1'b0;
    // First enabled edge after reset release must accept start.
    run_check("post_reset", 2'b01, 32'd6, 32'd7, 0, 0, 0, 34);

    // Table vectors, each followed by idle cycles to check pulse width and hold.
    foreach (vecs[i]) begin
      logic [31:0] mh, ml;
      int lat;
      bit ok;
      start_op(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(0, 0, 0, lat, ok);
      chk($sformatf("vec%0d latency", i), 64'(lat), 64'(34));
      chk($sformatf("vec%0d busy", i), 64'(ok), 64'(1));
      chk($sformatf("vec%0d hilo", i), {hi, lo}, {vecs[i].exp_hi, vecs[i].exp_lo});
      model(vecs[i].op, vecs[i].a, vecs[i].b, mh, ml);
      chk($sformatf("vec%0d model", i), {hi, lo}, {mh, ml});
      repeat (3) @(negedge clk);
      chk($sformatf("vec%0d done_pulse", i), {62'b0, busy, done}, 64'(0));
      chk($sformatf("vec%0d hold", i), {hi, lo}, {vecs[i].exp_hi, vecs[i].exp_lo});
    end

    // Start during RUN with different operands is ignored.
    run_check("ignore_start", 2'b01, 32'h12345678, 32'h9ABCDEF0, 0, 0, 10, 34);
    @(negedge clk);

    // Five stalled cycles mid-RUN extend latency to 39.
    run_check("stall", 2'b00, 32'hFFFF0001, 32'h00012345, 10, 5, 0, 39);
    @(negedge clk);

    // Back-to-back: second start accepted in the DONE cycle.
    run_check("b2b_divu", 2'b11, 32'd17, 32'd5, 0, 0, 0, 34);
    run_check("b2b_multu", 2'b01, 32'd3, 32'd4, 0, 0, 0, 34);
    @(negedge clk);

    // Reset at cycle 20 of RUN: immediate clear, no done afterwards.
    begin
      bit saw_done;
      start_op(2'b01, 32'hCAFEBABE, 32'h01234567);
      repeat (20) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midrun_reset busy", 64'(busy), 64'(0));
      chk("midrun_reset done", 64'(done), 64'(0));
      chk("midrun_reset hilo", {hi, lo}, 64'(0));
      saw_done = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (done || busy) saw_done = 1'b1;
      end
      chk("midrun_reset no_done", 64'(saw_done), 64'(0));
    end

    // Random operations against the reference model.
    for (int i = 0; i < 30; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom);
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = {28'b0, rb[3:0]};
      run_check($sformatf("rand%0d", i), ro, ra, rb, 0, 0, 0, 34);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
